// File: rtl/relobi_pkg.sv
// ============================================================================
// relobi_pkg : shared types, voters and constants for the relOBI pipeline cut
// Rev 1.0
// ============================================================================
`default_nettype none

package relobi_pkg;

  localparam int unsigned RelobiCutDepth = 2;

  typedef struct packed {
    logic [1:0] count;
    logic       rptr;
  } tmr_occ_t;

  typedef tmr_occ_t [2:0] tmr_occ_arr_t;

  typedef struct packed {
    logic UseRReady;
  } relobi_cfg_t;

  localparam relobi_cfg_t RelobiDefaultCfg = '{UseRReady: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  other_ecc;
  } relobi_a_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  other_ecc;
  } relobi_r_t;

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] rready;
    relobi_a_t  a;
  } relobi_req_default_t;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] rvalid;
    relobi_r_t  r;
  } relobi_rsp_default_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
  endfunction

  function automatic logic lanes_differ(input logic [2:0] v);
    return (v != 3'b000) && (v != 3'b111);
  endfunction

  function automatic tmr_occ_t vote_occ(input tmr_occ_arr_t c);
    return tmr_occ_t'((c[0] & c[1]) | (c[1] & c[2]) | (c[0] & c[2]));
  endfunction

endpackage

`default_nettype wire

// File: rtl/relobi_tmr_spill.sv
// ============================================================================
// relobi_tmr_spill : 2-entry spill buffer, occupancy stored in triplicate
// Rev 1.0
// ============================================================================
`default_nettype none

module relobi_tmr_spill
  import relobi_pkg::*;
#(
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  valid_i,
  output logic  ready_o,
  input  data_t data_i,
  output logic  valid_o,
  input  logic  ready_i,
  output data_t data_o,
  output logic  err_o
);

  tmr_occ_arr_t occ_q;
  tmr_occ_t     occ_v;
  tmr_occ_t     occ_d;
  data_t        data_q [RelobiCutDepth];
  logic         in_fire;
  logic         out_fire;
  logic         wptr;

  always_comb begin
    occ_v    = vote_occ(occ_q);
    ready_o  = occ_v.count < 2'(RelobiCutDepth);
    valid_o  = occ_v.count != 2'd0;
    in_fire  = valid_i & ready_o;
    out_fire = valid_o & ready_i;
    // Write slot sits behind the oldest entry; only reachable with count 0 or 1.
    wptr     = occ_v.rptr ^ occ_v.count[0];
    occ_d       = occ_v;
    occ_d.count = occ_v.count + {1'b0, in_fire} - {1'b0, out_fire};
    occ_d.rptr  = occ_v.rptr ^ out_fire;
    data_o   = data_q[occ_v.rptr];
    err_o    = (occ_q[0] != occ_q[1]) || (occ_q[1] != occ_q[2]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q <= '0;
      for (int i = 0; i < RelobiCutDepth; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      occ_q <= {3{occ_d}};
      if (in_fire) begin
        data_q[wptr] <= data_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/relobi_cut.sv
// ============================================================================
// relobi_cut : full-throughput register cut on relOBI A and R channels
// Optional error counter: RELOBI_CUT_ERR_COUNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module relobi_cut
  import relobi_pkg::*;
#(
  parameter relobi_cfg_t Cfg          = RelobiDefaultCfg,
  parameter type         relobi_req_t = relobi_req_default_t,
  parameter type         relobi_rsp_t = relobi_rsp_default_t,
  parameter type         a_chan_t     = relobi_a_t,
  parameter type         r_chan_t     = relobi_r_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  relobi_req_t sbr_req_i,
  output relobi_rsp_t sbr_rsp_o,
  output relobi_req_t mgr_req_o,
  input  relobi_rsp_t mgr_rsp_i,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  logic    req_v, gnt_v, rvalid_v;
  logic    a_ready, a_valid, a_err;
  a_chan_t a_data;
  logic    r_ready, r_valid, r_err, rready_mis;
  r_chan_t r_data;
  logic    mismatch;
  logic    err_q;

  assign req_v    = maj3(sbr_req_i.req);
  assign gnt_v    = maj3(mgr_rsp_i.gnt);
  assign rvalid_v = maj3(mgr_rsp_i.rvalid);

  relobi_tmr_spill #(
    .data_t (a_chan_t)
  ) u_a_spill (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (req_v),
    .ready_o (a_ready),
    .data_i  (sbr_req_i.a),
    .valid_o (a_valid),
    .ready_i (gnt_v),
    .data_o  (a_data),
    .err_o   (a_err)
  );

  generate
    if (Cfg.UseRReady) begin : g_rready
      logic rready_v;
      assign rready_v   = maj3(sbr_req_i.rready);
      assign rready_mis = lanes_differ(sbr_req_i.rready);

      relobi_tmr_spill #(
        .data_t (r_chan_t)
      ) u_r_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (rvalid_v),
        .ready_o (r_ready),
        .data_i  (mgr_rsp_i.r),
        .valid_o (r_valid),
        .ready_i (rready_v),
        .data_o  (r_data),
        .err_o   (r_err)
      );
    end else begin : g_no_rready
      logic [2:0] rvld_q;
      r_chan_t    r_q;
      logic       unused_rready;

      assign unused_rready = ^sbr_req_i.rready;
      assign rready_mis    = 1'b0;
      assign r_ready       = 1'b1;
      assign r_valid       = maj3(rvld_q);
      assign r_data        = r_q;
      assign r_err         = lanes_differ(rvld_q);

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          rvld_q <= '0;
          r_q    <= '0;
        end else begin
          rvld_q <= {3{rvalid_v}};
          if (rvalid_v) begin
            r_q <= mgr_rsp_i.r;
          end
        end
      end
    end
  endgenerate

  // Handshake outputs are masked combinationally while reset is held.
  always_comb begin
    sbr_rsp_o        = '0;
    mgr_req_o        = '0;
    sbr_rsp_o.gnt    = {3{a_ready & rst_ni}};
    sbr_rsp_o.rvalid = {3{r_valid & rst_ni}};
    sbr_rsp_o.r      = r_data;
    mgr_req_o.req    = {3{a_valid & rst_ni}};
    mgr_req_o.rready = {3{r_ready & rst_ni}};
    mgr_req_o.a      = a_data;
  end

  assign mismatch = lanes_differ(sbr_req_i.req) | lanes_differ(mgr_rsp_i.gnt) |
                    lanes_differ(mgr_rsp_i.rvalid) | rready_mis | a_err | r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= mismatch;
    end
  end

  assign err_o = err_q;

`ifdef RELOBI_CUT_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= 8'd0;
    end else if (mismatch && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_relobi_cut.sv
// ============================================================================
// tb_relobi_cut : directed checks of relobi_cut in both R-channel modes
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_relobi_cut;
  import relobi_pkg::*;

  localparam relobi_cfg_t CfgRR = '{UseRReady: 1'b1};
  localparam relobi_cfg_t CfgNR = '{UseRReady: 1'b0};
`ifdef RELOBI_CUT_ERR_COUNT_EN
  localparam int CntEn = 1;
`else
  localparam int CntEn = 0;
`endif

  logic clk;
  logic rst_n;
  relobi_req_default_t req1, mreq1, req0, mreq0;
  relobi_rsp_default_t srsp1, mrsp1, srsp0, mrsp0;
  logic       err1, err0;
  logic [7:0] cnt1, cnt0;
  relobi_r_t  exp_r;
  int checks;
  int errors;

  relobi_cut #(.Cfg(CfgRR)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sbr_req_i (req1),
    .sbr_rsp_o (srsp1),
    .mgr_req_o (mreq1),
    .mgr_rsp_i (mrsp1),
    .err_o     (err1),
    .err_cnt_o (cnt1)
  );

  relobi_cut #(.Cfg(CfgNR)) dut0 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .sbr_req_i (req0),
    .sbr_rsp_o (srsp0),
    .mgr_req_o (mreq0),
    .mgr_rsp_i (mrsp0),
    .err_o     (err0),
    .err_cnt_o (cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req1 = '0; mrsp1 = '0; req0 = '0; mrsp0 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", srsp1.gnt, 3'b000);
    check("rst_req", mreq1.req, 3'b000);
    check("rst_err", err1, 1'b0);
    check("rst_cnt", cnt1, 8'd0);
    check("rst_rvalid0", srsp0.rvalid, 3'b000);
    rst_n = 1'b1;
    #1;
    check("gnt_after_rst", srsp1.gnt, 3'b111);

    // Back-to-back transfers with downstream always granting
    mrsp1.gnt   = 3'b111;
    req1.req    = 3'b111;
    req1.rready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      req1.a.addr = 32'h10 + 32'(4 * i);
      @(posedge clk); #1;
      check("b2b_req", mreq1.req, 3'b111);
      check("b2b_addr", mreq1.a.addr, 32'h10 + 32'(4 * i));
      check("b2b_gnt", srsp1.gnt, 3'b111);
    end
    req1.req = 3'b000;
    @(posedge clk); #1;
    check("b2b_drain", mreq1.req, 3'b000);

    // Backpressure: downstream grant low for five cycles
    mrsp1.gnt   = 3'b000;
    req1.req    = 3'b111;
    req1.a.addr = 32'h20;
    @(posedge clk); #1;
    check("bp_gnt1", srsp1.gnt, 3'b111);
    req1.a.addr = 32'h24;
    @(posedge clk); #1;
    check("bp_full", srsp1.gnt, 3'b000);
    req1.a.addr = 32'h28;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_gnt", srsp1.gnt, 3'b000);
      check("bp_hold_addr", mreq1.a.addr, 32'h20);
    end
    mrsp1.gnt = 3'b111;
    @(posedge clk); #1;
    check("bp_regnt", srsp1.gnt, 3'b111);
    check("bp_drain1", mreq1.a.addr, 32'h24);
    @(posedge clk); #1;
    check("bp_drain2", mreq1.a.addr, 32'h28);
    req1.req = 3'b000;
    @(posedge clk); #1;
    check("bp_empty", mreq1.req, 3'b000);

    // Single flipped lane on upstream req
    req1.req    = 3'b011;
    req1.a.addr = 32'h30;
    @(posedge clk); #1;
    check("flip_err", err1, 1'b1);
    check("flip_cnt", cnt1, 8'(CntEn));
    check("flip_req", mreq1.req, 3'b111);
    check("flip_addr", mreq1.a.addr, 32'h30);
    req1.req = 3'b000;
    @(posedge clk); #1;
    check("flip_err_clr", err1, 1'b0);
    check("flip_drain", mreq1.req, 3'b000);

    // Corrupt one occupancy copy while one entry is held
    mrsp1.gnt   = 3'b000;
    req1.req    = 3'b111;
    req1.a.addr = 32'h40;
    @(posedge clk); #1;
    req1.req = 3'b000;
    force dut.u_a_spill.occ_q = 9'b010_101_010;
    #1;
    release dut.u_a_spill.occ_q;
    #1;
    check("upset_req", mreq1.req, 3'b111);
    check("upset_gnt", srsp1.gnt, 3'b111);
    check("upset_addr", mreq1.a.addr, 32'h40);
    @(posedge clk); #1;
    check("upset_err", err1, 1'b1);
    check("upset_scrub", dut.u_a_spill.occ_q, 9'b010_010_010);
    check("upset_cnt", cnt1, 8'(2 * CntEn));
    mrsp1.gnt = 3'b111;
    @(posedge clk); #1;
    check("upset_err_clr", err1, 1'b0);
    check("upset_drain", mreq1.req, 3'b000);

    // R channel with rready
    exp_r = '{rdata: 32'hCAFE0001, err: 1'b1, other_ecc: 8'h5A};
    mrsp1.rvalid = 3'b111;
    mrsp1.r      = exp_r;
    @(posedge clk); #1;
    check("rr_rvalid", srsp1.rvalid, 3'b111);
    check("rr_data", srsp1.r, exp_r);
    mrsp1.rvalid = 3'b000;
    @(posedge clk); #1;
    check("rr_empty", srsp1.rvalid, 3'b000);

    // Single-register R stage, three consecutive beats
    mrsp0.rvalid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      exp_r = '{rdata: 32'hA0000000 + 32'(i), err: i[0], other_ecc: 8'hC3 ^ 8'(i)};
      mrsp0.r = exp_r;
      if (i == 0) begin
        check("nr_pre", srsp0.rvalid, 3'b000);
      end
      @(posedge clk); #1;
      check("nr_rvalid", srsp0.rvalid, 3'b111);
      check("nr_data", srsp0.r, exp_r);
    end
    mrsp0.rvalid = 3'b000;
    @(posedge clk); #1;
    check("nr_end", srsp0.rvalid, 3'b000);
    check("nr_err", err0, 1'b0);

    // Reset with both buffers full
    mrsp1.gnt    = 3'b000;
    req1.req     = 3'b111;
    req1.rready  = 3'b000;
    req1.a.addr  = 32'h50;
    mrsp1.rvalid = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("full_gnt", srsp1.gnt, 3'b000);
    check("full_req", mreq1.req, 3'b111);
    check("full_rvalid", srsp1.rvalid, 3'b111);
    check("full_rready", mreq1.rready, 3'b000);
    rst_n = 1'b0;
    #1;
    check("rstmid_req", mreq1.req, 3'b000);
    check("rstmid_rvalid", srsp1.rvalid, 3'b000);
    check("rstmid_gnt", srsp1.gnt, 3'b000);
    req1.req     = 3'b000;
    mrsp1.rvalid = 3'b000;
    mrsp1.gnt    = 3'b111;
    req1.rready  = 3'b111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_gnt", srsp1.gnt, 3'b111);
    check("post_req", mreq1.req, 3'b000);
    check("post_rvalid", srsp1.rvalid, 3'b000);
    check("post_cnt", cnt1, 8'd0);
    @(posedge clk); #1;
    check("post_stale_req", mreq1.req, 3'b000);
    check("post_stale_rvalid", srsp1.rvalid, 3'b000);
    check("post_err", err1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/relobi_cut.md
# relobi_cut

Pipeline cut for the reliable OBI bus: a full-throughput register stage on both the A (request) and R (response) channels. It sits directly upstream of the relOBI-to-OBI decoding stage to break long timing paths. Payloads stay ECC-encoded and pass through unmodified. Handshake inputs are TMR-voted, and internal occupancy state is held and scrubbed in triplicate. Voter disagreements are reported.

## Interface
Parameters:
- Cfg, obi_pkg::ObiDefaultConfig, bus configuration; Cfg.UseRReady selects the R-channel mode.
- relobi_req_t, logic, reliable request struct; fields req[2:0], rready[2:0] (if UseRReady), a (encoded).
- relobi_rsp_t, logic, reliable response struct; fields gnt[2:0], rvalid[2:0], r (encoded).

Ports:
- clk_i  in  1  clock; the block uses this single clock.
- rst_ni  in  1  reset; synchronous and active-low.
- sbr_req_i  in  relobi_req_t  request from the upstream manager.
- sbr_rsp_o  out  relobi_rsp_t  response to the upstream manager.
- mgr_req_o  out  relobi_req_t  request toward the downstream decoder.
- mgr_rsp_i  in  relobi_rsp_t  response from the downstream decoder.
- err_o  out  1  single-cycle pulse on any voter mismatch or state-copy mismatch.
- err_cnt_o  out  8  saturating mismatch count (see Configuration).

## Operation
- Handshake inputs sbr_req_i.req, mgr_rsp_i.gnt, mgr_rsp_i.rvalid and sbr_req_i.rready are each majority-voted before use.
- All handshake outputs are driven as three identical copies of one internal bit.
- A channel: 2-entry spill buffer.
  - Transfer in when voted req && sbr gnt.
  - Transfer out when mgr req && voted mgr gnt.
  - sbr_rsp_o.gnt = {3{occupancy < 2}}.
  - mgr_req_o.req = {3{occupancy > 0}}.
  - mgr_req_o.a = oldest entry.
  - Entries leave in FIFO order.
- R channel, Cfg.UseRReady=1: same 2-entry spill structure.
  - mgr_req_o.rready = {3{occupancy < 2}}.
  - sbr_rsp_o.rvalid = {3{occupancy > 0}}.
  - Transfer out requires voted sbr rready.
- R channel, Cfg.UseRReady=0: single register stage.
  - Loads whenever voted mgr rvalid is high.
  - sbr_rsp_o.rvalid follows one cycle later.
  - No backpressure.
- Occupancy state per buffer: 2-bit count plus 1-bit read pointer, stored in three copies.
  - Each cycle the next state is computed from the voted current state.
  - The result is written to all three copies, which scrubs single upsets.
- Payload bits (a, r, including other_ecc) are stored and forwarded verbatim; there is no ECC decode or re-encode.
- Simultaneous in/out on a channel: occupancy is unchanged and throughput is one transfer per cycle.
  - At full (2), an input transfer is impossible because gnt/rready is low.
  - At empty, an output transfer is impossible.
- Reset mid-operation:
  - All entries are dropped and occupancy returns to 0 at the next edge.
  - Combinationally, while rst_ni is low, gnt and rready outputs are forced to 3'b000 and req/rvalid outputs to 3'b000.
- Reset values: all handshake outputs 0, payload registers 0, err_o 0, err_cnt_o 0.

## Timing
- Latency: 1 cycle, input transfer to output valid, on both channels.
- Upstream readiness (gnt/rready) depends only on registered state, so there is no combinational path from mgr side to sbr side.
- Output req/rvalid depend only on registered state.
- err_o is registered and asserts the cycle after the mismatch.
- err_cnt_o updates in the same cycle as err_o.

## Configuration
- RELOBI_CUT_ERR_COUNT_EN defined:
  - err_cnt_o is an 8-bit counter incremented by 1 per cycle with err_o high.
  - It saturates at 255 and clears only on reset.
- Not defined:
  - No counter is synthesized and err_cnt_o is tied to 8'd0.
  - err_o is unaffected.

## Structure
- Shared package relobi_pkg holds:
  - tmr_occ_t: a packed struct {count[1:0], rptr} and its 3-copy array type.
  - Constant RelobiCutDepth = 2.
- Sub-module relobi_tmr_spill: one generic 2-entry buffer with TMR occupancy and an error flag.
  - Instantiated once for A.
  - Instantiated once for R when UseRReady=1.

## Test plan
- Back-to-back writes with mgr gnt held high:
  - Four A transfers with addr 0x10/0x14/0x18/0x1C appear on mgr_req_o one cycle later, in order.
  - sbr gnt stays 3'b111 throughout.
- mgr gnt low for 5 cycles with upstream req held:
  - Two entries are accepted, then sbr gnt drops to 3'b000.
  - On release the entries drain in order and gnt returns to 3'b111 after the first drain.
- Single flipped lane, sbr_req_i.req = 3'b011 for one cycle:
  - The transfer is accepted normally.
  - err_o pulses once; err_cnt_o = 1 with the macro defined, 0 without.
- Force one occupancy copy to a wrong value mid-stream:
  - Voted behaviour is unchanged and the copy is corrected next cycle.
  - err_o pulses once.
- UseRReady=0 with rvalid on 3 consecutive cycles:
  - sbr rvalid appears on 3 consecutive cycles, delayed by 1.
  - rdata is bit-exact including ECC bits.
- Assert rst_ni low with both buffers full:
  - Outputs go to 3'b000 immediately.
  - After release, occupancy is 0 and no stale transfer appears.
